// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM slave, 2^ADDR_W x 32-bit; independent single-outstanding read and write FSMs.
// Latency: first read beat one cycle after AR accept; B response one cycle after the wlast beat.
// Backpressure: rvalid/rdata hold while rready=0; AXI_SLAVE_RAND_STALL_EN adds LFSR-gated ready/valid stalls.
module axi_sram_slave #(
    parameter int ADDR_W = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic w_gate;

`ifdef AXI_SLAVE_RAND_STALL_EN
    localparam bit STALL_EN = 1'b1;
    logic [7:0] r_lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
    assign w_gate = r_lfsr[0];
`else
    localparam bit STALL_EN = 1'b0;
    assign w_gate = 1'b1;
`endif

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + 32'd4 : a;
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    // ---------------- read path ----------------
    rstate_t     r_rstate;
    logic        r_arready;
    logic        r_rvalid;
    logic        r_rlast;
    logic [3:0]  r_rid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_raddr;
    logic [3:0]  r_rlen;
    logic [3:0]  r_rcnt;
    logic [1:0]  r_rburst;

    logic [31:0] w_raddr_nxt;
    logic [3:0]  w_rcnt_nxt;
    logic        w_rerr;

    assign w_raddr_nxt = next_addr(r_raddr, r_rburst);
    assign w_rcnt_nxt  = r_rcnt + 4'd1;
    assign w_rerr      = r_rburst[1];

    assign arready = r_arready & w_gate;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

    // rdata is registered from mem at the accepting edge, so a write on that same edge is not seen
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= 4'd0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= 32'd0;
            r_raddr   <= 32'd0;
            r_rlen    <= 4'd0;
            r_rcnt    <= 4'd0;
            r_rburst  <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_raddr   <= araddr;
                        r_rlen    <= arlen;
                        r_rburst  <= arburst;
                        r_rcnt    <= 4'd0;
                        r_rlast   <= (arlen == 4'd0);
                        r_rresp   <= arburst[1] ? RESP_SLVERR : RESP_OKAY;
                        r_rdata   <= arburst[1] ? 32'd0 : mem[word_idx(araddr)];
                        r_rvalid  <= !STALL_EN;
                    end
                end
                R_DATA: begin
                    if (!r_rvalid) begin
                        if (w_gate) r_rvalid <= 1'b1;
                    end else if (rready) begin
                        if (r_rlast) begin
                            r_rstate  <= R_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rcnt  <= w_rcnt_nxt;
                            r_raddr <= w_raddr_nxt;
                            r_rlast <= (w_rcnt_nxt == r_rlen);
                            r_rdata <= w_rerr ? 32'd0 : mem[word_idx(w_raddr_nxt)];
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    wstate_t     r_wstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [3:0]  r_bid;
    logic [1:0]  r_bresp;
    logic [31:0] r_waddr;
    logic [3:0]  r_wlen;
    logic [4:0]  r_wcnt;
    logic [1:0]  r_wburst;

    logic        w_wr_hs;
    logic        w_mem_we;
    logic        w_wlen_bad;

    assign awready = r_awready & w_gate;
    assign wready  = r_wready & w_gate;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

    assign w_wr_hs    = (r_wstate == W_DATA) && wvalid && wready;
    assign w_mem_we   = w_wr_hs && !r_wburst[1];
    assign w_wlen_bad = (r_wcnt != {1'b0, r_wlen});

    // beat counter saturates so overlong bursts still flag a length error
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 4'd0;
            r_bresp   <= RESP_OKAY;
            r_waddr   <= 32'd0;
            r_wlen    <= 4'd0;
            r_wcnt    <= 5'd0;
            r_wburst  <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= awid;
                        r_waddr   <= awaddr;
                        r_wlen    <= awlen;
                        r_wburst  <= awburst;
                        r_wcnt    <= 5'd0;
                    end
                end
                W_DATA: begin
                    if (w_wr_hs) begin
                        r_waddr <= next_addr(r_waddr, r_wburst);
                        if (r_wcnt != 5'h1f) r_wcnt <= r_wcnt + 5'd1;
                        if (wlast) begin
                            r_wstate <= W_RESP;
                            r_wready <= 1'b0;
                            r_bresp  <= (r_wburst[1] || w_wlen_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_bvalid <= !STALL_EN;
                        end
                    end
                end
                W_RESP: begin
                    if (!r_bvalid) begin
                        if (w_gate) r_bvalid <= 1'b1;
                    end else if (bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_we && wstrb[b]) mem[word_idx(r_waddr)][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 12: word-address bits; memory depth 2^ADDR_W x 32 bit (16 KiB at default).
REQ-002 aclk  input  1  single clock; all logic on rising edge.
REQ-003 aresetn  input  1  asynchronous, active-low reset.
REQ-004 arid  input  4  read burst ID.
REQ-005 araddr  input  32  read start byte address.
REQ-006 arlen  input  4  read beats minus one.
REQ-007 arburst  input  2  read burst type.
REQ-008 arvalid  input  1  read address valid.
REQ-009 arready  output  1  read address accept.
REQ-010 rid  output  4  echo of accepted arid.
REQ-011 rdata  output  32  read beat data.
REQ-012 rresp  output  2  read beat response.
REQ-013 rlast  output  1  final read beat.
REQ-014 rvalid  output  1  read beat valid.
REQ-015 rready  input  1  master accepts read beat.
REQ-016 awid  input  4  write burst ID.
REQ-017 awaddr  input  32  write start byte address.
REQ-018 awlen  input  4  write beats minus one.
REQ-019 awburst  input  2  write burst type.
REQ-020 awvalid  input  1  write address valid.
REQ-021 awready  output  1  write address accept.
REQ-022 wdata  input  32  write beat data.
REQ-023 wstrb  input  4  byte lane enables.
REQ-024 wlast  input  1  final write beat.
REQ-025 wvalid  input  1  write beat valid.
REQ-026 wready  output  1  write beat accept.
REQ-027 bid  output  4  echo of accepted awid.
REQ-028 bresp  output  2  write response.
REQ-029 bvalid  output  1  write response valid.
REQ-030 bready  input  1  master accepts response.

Function
REQ-031 Read and write paths SHALL be independent FSMs; each holds one outstanding burst; all transfers 4-byte; size, lock, cache, prot, wid not ported.
REQ-032 Read FSM R_IDLE->R_DATA: arready=1 only in R_IDLE; on arvalid&arready latch id/addr/len/burst, clear beat count; next cycle rvalid=1.
REQ-033 In R_DATA: rdata = mem[addr[ADDR_W+1:2]]; rvalid&rready advances beat; rlast=1 when count==len; handshake with rlast returns to R_IDLE; rvalid/rdata held stable while rready=0.
REQ-034 Write FSM W_IDLE->W_DATA->W_RESP: awready=1 only in W_IDLE; wready=1 only in W_DATA; each wvalid&wready writes enabled byte lanes; wvalid&wready&wlast -> W_RESP; bvalid=1 in W_RESP until bready, then W_IDLE.
REQ-035 Address: FIXED (00) constant; INCR (01) +4 per beat, 32-bit wrap; index wraps modulo depth (upper bits ignored).
REQ-036 WRAP (10)/reserved (11): burst completes with all beats, rresp/bresp = SLVERR (2'b10), rdata=0, writes suppressed; otherwise resp OKAY (2'b00).
REQ-037 Write beat count ignored for termination: wlast alone ends burst; wlast beat count != awlen+1 -> bresp SLVERR, data already written kept.
REQ-038 Same-cycle read and write to one word: read returns pre-write value; write visible from next cycle.

Reset
REQ-039 aresetn low SHALL force R_IDLE/W_IDLE, rvalid=rlast=wready=bvalid=0, arready=awready=1 (0 under REQ-040 when LFSR bit low), rid=bid=0, rresp=bresp=0, rdata=0; mid-burst state discarded; memory contents not reset.

Configuration
REQ-040 AXI_SLAVE_RAND_STALL_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset, steps every cycle) bit0 gates arready, awready, wready and first assertion of each rvalid/bvalid (never withdraws an asserted valid); undefined: no gating, latencies per REQ-032..034.

Verification
REQ-041 Write awaddr=0x100, awlen=3, INCR, data 1..4, wstrb=F; read same -> rdata 1,2,3,4, rlast on beat 4, bresp/rresp 00, rid/bid echo.
REQ-042 Write 0xAABBCCDD then wstrb=0101 data 0x11223344 at 0x40; read -> 0xAA22CC44.
REQ-043 Read arlen=2 with rready low 5 cycles on beat 2 -> rvalid/rdata stable, exactly 3 beats total.
REQ-044 AW with awburst=10 -> memory unchanged, bresp=10; AR arburst=10 -> rdata 0, rresp=10 each beat.
REQ-045 Assert aresetn low mid read burst -> rvalid=0 immediately; new burst after reset returns correct data.
REQ-046 FIXED read arlen=3 at 0x8 -> four beats of mem[2]; ADDR_W=12, addr 0x4000 aliases 0x0.
